// File: rtl/oh_counter_array_if.sv
// Bus bundle for oh_counter_array: per-channel controls in, counts and flags out.
// OH_COUNTER_ARRAY_SNAPSHOT_EN adds the snap strobe and the snap_count capture bus.
interface oh_counter_array_if #(
   parameter int N  = 32,
   parameter int CH = 4,
   parameter int S  = 8
);
   logic [CH-1:0]   en;
   logic [CH-1:0]   dec;
   logic [CH*S-1:0] step;
   logic [CH-1:0]   load;
   logic [CH*N-1:0] load_data;
   logic [1:0]      mode;
   logic [N-1:0]    limit;
   logic [CH*N-1:0] count;
   logic [CH-1:0]   wrap;
   logic [CH-1:0]   at_top;
   logic [CH-1:0]   at_zero;
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
   logic            snap;
   logic [CH*N-1:0] snap_count;

   modport master (
      output en, dec, step, load, load_data, mode, limit, snap,
      input  count, wrap, at_top, at_zero, snap_count
   );

   modport slave (
      input  en, dec, step, load, load_data, mode, limit, snap,
      output count, wrap, at_top, at_zero, snap_count
   );
`else
   modport master (
      output en, dec, step, load, load_data, mode, limit,
      input  count, wrap, at_top, at_zero
   );

   modport slave (
      input  en, dec, step, load, load_data, mode, limit,
      output count, wrap, at_top, at_zero
   );
`endif
endinterface

// File: rtl/oh_counter_array.sv
// Bank of CH independent N-bit up/down counters sharing one wrap mode and limit.
// Optional OH_COUNTER_ARRAY_SNAPSHOT_EN adds an atomic snapshot register of all counts.
module oh_counter_array #(
   parameter int N  = 32,
   parameter int CH = 4,
   parameter int S  = 8
) (
   input  logic              clk,
   input  logic              reset,
   oh_counter_array_if.slave bus
);

   logic [N-1:0]  cnt_q  [CH];
   logic [N-1:0]  cnt_d  [CH];
   logic [CH-1:0] wrap_q;
   logic [CH-1:0] wrap_d;
   logic [N-1:0]  stp    [CH];
   logic [N:0]    sum    [CH];
   logic [N-1:0]  diff   [CH];
   logic [CH-1:0] ovf;
   logic [CH-1:0] unf;
   logic [N-1:0]  top;
   logic          sat_mode;
   logic          lim_mode;

   // Mode 11 is reserved and behaves exactly like plain modular wrap.
   always_comb begin
      sat_mode = (bus.mode == 2'b01);
      lim_mode = (bus.mode == 2'b10);
      top      = lim_mode ? bus.limit : {N{1'b1}};
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         stp[i]    = N'(bus.step[i*S +: S]);
         sum[i]    = {1'b0, cnt_q[i]} + {1'b0, stp[i]};
         diff[i]   = cnt_q[i] - stp[i];
         ovf[i]    = (sum[i] > {1'b0, top});
         unf[i]    = (stp[i] > cnt_q[i]);
         cnt_d[i]  = cnt_q[i];
         wrap_d[i] = 1'b0;
         if (bus.load[i]) begin
            cnt_d[i] = bus.load_data[i*N +: N];
         end else if (bus.en[i] && (stp[i] != '0)) begin
            // A zero step must stay silent even when a load parked the count above limit.
            if (!bus.dec[i]) begin
               if (ovf[i]) begin
                  wrap_d[i] = 1'b1;
                  if (sat_mode)
                     cnt_d[i] = top;
                  else if (lim_mode)
                     cnt_d[i] = '0;
                  else
                     cnt_d[i] = sum[i][N-1:0];
               end else begin
                  cnt_d[i] = sum[i][N-1:0];
               end
            end else begin
               if (unf[i]) begin
                  wrap_d[i] = 1'b1;
                  if (sat_mode)
                     cnt_d[i] = '0;
                  else if (lim_mode)
                     cnt_d[i] = bus.limit;
                  else
                     cnt_d[i] = diff[i];
               end else begin
                  cnt_d[i] = diff[i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
         wrap_q <= '0;
      end else begin
         for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
         wrap_q <= wrap_d;
      end
   end

   always_comb begin
      bus.count   = '0;
      bus.at_top  = '0;
      bus.at_zero = '0;
      for (int i = 0; i < CH; i++) begin
         bus.count[i*N +: N] = cnt_q[i];
         bus.at_top[i]       = (cnt_q[i] == top);
         bus.at_zero[i]      = (cnt_q[i] == '0);
      end
   end

   assign bus.wrap = wrap_q;

`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
   logic [CH*N-1:0] snap_q;

   // Captures the counts visible this cycle, before any concurrent en/load lands.
   always_ff @(posedge clk) begin
      if (reset)
         snap_q <= '0;
      else if (bus.snap)
         snap_q <= bus.count;
   end

   assign bus.snap_count = snap_q;
`endif

endmodule

// File: tb/tb_oh_counter_array.sv
// Self-checking bench for oh_counter_array (N=8, CH=4, S=4): directed plan steps then random traffic.
// Exercises the snapshot port when OH_COUNTER_ARRAY_SNAPSHOT_EN is defined.
module tb_oh_counter_array;
   localparam int N  = 8;
   localparam int CH = 4;
   localparam int S  = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   int   m_cnt  [CH];
   bit   m_wrap [CH];
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
   logic [CH*N-1:0] m_snap;
`endif

   always #5 clk = ~clk;

   oh_counter_array_if #(.N(N), .CH(CH), .S(S)) bus ();

   oh_counter_array #(.N(N), .CH(CH), .S(S)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the documented counting rules.
   task automatic model_update();
      int top, lim, md, st, c, s;
      md  = int'(bus.mode);
      lim = int'(bus.limit);
      top = (md == 2) ? lim : 255;
      if (reset) begin
         for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = 0;
            m_wrap[i] = 1'b0;
         end
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
         m_snap = '0;
`endif
         return;
      end
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
      if (bus.snap)
         for (int i = 0; i < CH; i++) m_snap[i*N +: N] = N'(m_cnt[i]);
`endif
      for (int i = 0; i < CH; i++) begin
         st = int'(bus.step[i*S +: S]);
         c  = m_cnt[i];
         m_wrap[i] = 1'b0;
         if (bus.load[i]) begin
            c = int'(bus.load_data[i*N +: N]);
         end else if (bus.en[i] && st != 0) begin
            if (!bus.dec[i]) begin
               s = c + st;
               if (s > top) begin
                  m_wrap[i] = 1'b1;
                  c = (md == 1) ? 255 : (md == 2) ? 0 : s % 256;
               end else begin
                  c = s;
               end
            end else begin
               if (st > c) begin
                  m_wrap[i] = 1'b1;
                  c = (md == 1) ? 0 : (md == 2) ? lim : c - st + 256;
               end else begin
                  c = c - st;
               end
            end
         end
         m_cnt[i] = c;
      end
   endtask

   task automatic checkOutput();
      logic [CH*N-1:0] exp_count;
      logic [CH-1:0]   exp_wrap, exp_top, exp_zero;
      int top;
      top = (bus.mode == 2'b10) ? int'(bus.limit) : 255;
      for (int i = 0; i < CH; i++) begin
         exp_count[i*N +: N] = N'(m_cnt[i]);
         exp_wrap[i]         = m_wrap[i];
         exp_top[i]          = (m_cnt[i] == top);
         exp_zero[i]         = (m_cnt[i] == 0);
      end
      check("count",   64'(bus.count),   64'(exp_count));
      check("wrap",    64'(bus.wrap),    64'(exp_wrap));
      check("at_top",  64'(bus.at_top),  64'(exp_top));
      check("at_zero", 64'(bus.at_zero), 64'(exp_zero));
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
      check("snap_count", 64'(bus.snap_count), 64'(m_snap));
`endif
   endtask

   task automatic applyStimulus();
      model_update();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic set_ch(input int ch, input bit e, input bit d, input int st);
      bus.en[ch]          = e;
      bus.dec[ch]         = d;
      bus.step[ch*S +: S] = S'(st);
   endtask

   task automatic load_ch(input int ch, input int val);
      bus.load[ch]             = 1'b1;
      bus.load_data[ch*N +: N] = N'(val);
   endtask

   task automatic idle_inputs();
      bus.en   = '0;
      bus.dec  = '0;
      bus.load = '0;
      bus.step = '0;
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
      bus.snap = 1'b0;
`endif
   endtask

   initial begin
      reset         = 1'b1;
      bus.load_data = '0;
      bus.mode      = 2'b00;
      bus.limit     = '0;
      idle_inputs();
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
      m_snap = '0;
`endif

      $display("[TB] reset with enables active");
      for (int i = 0; i < CH; i++) set_ch(i, 1'b1, 1'b0, 1);
      repeat (3) applyStimulus();
      check("reset_count", 64'(bus.count), 64'd0);
      check("reset_zero",  64'(bus.at_zero), 64'hF);
      reset = 1'b0;
      idle_inputs();

      $display("[TB] modular wrap");
      load_ch(0, 8'hFE);
      load_ch(1, 8'h01);
      applyStimulus();
      bus.load = '0;
      set_ch(0, 1'b1, 1'b0, 3);
      set_ch(1, 1'b1, 1'b1, 2);
      applyStimulus();
      check("wrap_inc_val", 64'(bus.count[7:0]),  64'h01);
      check("wrap_dec_val", 64'(bus.count[15:8]), 64'hFF);
      check("wrap_pulse",   64'(bus.wrap[1:0]),   64'h3);
      idle_inputs();
      applyStimulus();
      check("wrap_one_cycle", 64'(bus.wrap), 64'h0);

      $display("[TB] saturate");
      bus.mode = 2'b01;
      load_ch(2, 8'hFD);
      load_ch(3, 8'h04);
      applyStimulus();
      bus.load = '0;
      set_ch(2, 1'b1, 1'b0, 5);
      set_ch(3, 1'b1, 1'b1, 9);
      applyStimulus();
      check("sat_top",  64'(bus.count[23:16]), 64'hFF);
      check("sat_zero", 64'(bus.count[31:24]), 64'h00);
      applyStimulus();
      check("sat_hold",  64'(bus.count[23:16]), 64'hFF);
      check("sat_again", 64'(bus.wrap[2]),      64'h1);
      idle_inputs();

      $display("[TB] limit-modulo");
      bus.mode  = 2'b10;
      bus.limit = 8'd9;
      load_ch(0, 0);
      applyStimulus();
      bus.load = '0;
      set_ch(0, 1'b1, 1'b0, 1);
      repeat (9) applyStimulus();
      check("lim_at9",  64'(bus.count[7:0]), 64'd9);
      check("lim_top9", 64'(bus.at_top[0]),  64'h1);
      applyStimulus();
      check("lim_roll", 64'(bus.count[7:0]), 64'd0);
      check("lim_wrap", 64'(bus.wrap[0]),    64'h1);
      set_ch(0, 1'b1, 1'b1, 1);
      applyStimulus();
      check("lim_under", 64'(bus.count[7:0]), 64'd9);
      idle_inputs();
      load_ch(1, 8'd200);
      applyStimulus();
      bus.load = '0;
      set_ch(1, 1'b1, 1'b0, 0);
      applyStimulus();
      set_ch(1, 1'b1, 1'b1, 3);
      applyStimulus();
      check("lim_above_dec", 64'(bus.count[15:8]), 64'd197);
      idle_inputs();

      $display("[TB] priority");
      bus.mode = 2'b00;
      load_ch(1, 8'h55);
      set_ch(1, 1'b1, 1'b0, 7);
      applyStimulus();
      check("prio_load", 64'(bus.count[15:8]), 64'h55);
      reset = 1'b1;
      applyStimulus();
      check("prio_reset", 64'(bus.count), 64'd0);
      reset = 1'b0;
      idle_inputs();

`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
      $display("[TB] snapshot");
      load_ch(0, 8'h10);
      applyStimulus();
      bus.load = '0;
      set_ch(0, 1'b1, 1'b0, 1);
      bus.snap = 1'b1;
      applyStimulus();
      check("snap_cap", 64'(bus.snap_count[7:0]), 64'h10);
      check("snap_cnt", 64'(bus.count[7:0]),      64'h11);
      bus.snap = 1'b0;
      repeat (2) applyStimulus();
      check("snap_hold", 64'(bus.snap_count[7:0]), 64'h10);
      idle_inputs();
`endif

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         reset         = ($urandom_range(0, 49) == 0);
         bus.en        = CH'($urandom);
         bus.dec       = CH'($urandom);
         bus.load      = CH'($urandom) & CH'($urandom) & CH'($urandom);
         bus.step      = (CH*S)'($urandom);
         bus.load_data = (CH*N)'($urandom);
         if ($urandom_range(0, 15) == 0) bus.mode  = 2'($urandom);
         if ($urandom_range(0, 15) == 0) bus.limit = N'($urandom_range(0, 40));
`ifdef OH_COUNTER_ARRAY_SNAPSHOT_EN
         bus.snap = ($urandom_range(0, 3) == 0);
`endif
         applyStimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
